// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared types and timing constants for the HDMI data-island scheduler
//
// Purpose : island period/mode encoding consumed by the TMDS channel encoders,
//           plus the fixed lengths of the island timeline.
// Ports   : none (package)
package hdmi_pkg;

  typedef enum logic [2:0] {
    CTRL     = 3'd0,
    PREAMBLE = 3'd1,
    GB_LEAD  = 3'd2,
    DATA     = 3'd3,
    GB_TRAIL = 3'd4
  } island_mode_t;

  localparam int PREAMBLE_LEN = 8;
  localparam int GB_LEN       = 2;
  localparam int PKT_LEN      = 32;

endpackage

// File: rtl/hdmi_pkt_arbiter.sv
// rtl/hdmi_pkt_arbiter.sv - packet requester arbiter, fixed priority or round robin
//
// Purpose : picks one requester from (req & ~mask) when enable is high.
//           Default build: fixed priority, lowest index wins.
//           HDMI_ISLAND_RR_EN defined: round robin, the search starts at a
//           pointer that moves to one past the last granted index.
// Ports   : clk_pixel, reset  (HDMI_ISLAND_RR_EN only) pointer clock / async reset
//           req     [NUM_REQ]  level requests
//           mask    [NUM_REQ]  requesters excluded from this evaluation
//           enable             evaluation point; winner is zero when low
//           winner  [NUM_REQ]  one-hot winner, zero when nothing eligible
module hdmi_pkt_arbiter #(
  parameter int NUM_REQ = 4
) (
`ifdef HDMI_ISLAND_RR_EN
  input  logic               clk_pixel,
  input  logic               reset,
`endif
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic               enable,
  output logic [NUM_REQ-1:0] winner
);

  logic [NUM_REQ-1:0] cand;
  assign cand = req & ~mask;

`ifdef HDMI_ISLAND_RR_EN
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] idx;
  int               sum;

  // Walk the offsets from the far end so the candidate closest to ptr is
  // the last one written.
  always_comb begin
    winner  = '0;
    win_idx = '0;
    idx     = '0;
    sum     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = IDX_W'(sum);
      if (enable && cand[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
        win_idx     = idx;
      end
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (|winner) begin
      ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (enable && cand[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/hdmi_island_scheduler.sv
// rtl/hdmi_island_scheduler.sv - data-island timeline and packet slot scheduler
//
// Purpose : runs one data island per line inside horizontal blanking
//           (PREAMBLE, GB_LEAD, DATA packets of 32 clocks, GB_TRAIL) and
//           arbitrates packet requesters into the packet slots.
//           Optional HDMI_ISLAND_RR_EN selects round-robin arbitration.
// Ports   : clk_pixel, reset        pixel clock, async active-high reset
//           cx [10]                 current horizontal position
//           screen_start_x [10]     first active-video column
//           req [NUM_REQ]           level requests, held until granted
//           grant [NUM_REQ]         one-hot pulse in first clock of packet
//           pkt_sel                 index of packet being sent
//           pkt_bit [5]             bit counter within packet
//           mode [3]                hdmi_pkg::island_mode_t
//           data_island_period      high in GB_LEAD, DATA, GB_TRAIL
//           overrun                 sticky island-too-late flag
module hdmi_island_scheduler
  import hdmi_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ISL_START_X = 10,
  parameter int CTRL_MARGIN = 12,
  parameter int MAX_PKTS    = 18
) (
  input  logic                       clk_pixel,
  input  logic                       reset,
  input  logic [9:0]                 cx,
  input  logic [9:0]                 screen_start_x,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] pkt_sel,
  output logic [4:0]                 pkt_bit,
  output logic [2:0]                 mode,
  output logic                       data_island_period,
  output logic                       overrun
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_PKTS + 1);
  // Clocks from preamble start to end of trailing guard band for one packet.
  localparam int ISL_MIN_LEN = PREAMBLE_LEN + 2 * GB_LEN + PKT_LEN;
  // Seen from pkt_bit==31: next packet, trailing guard band, then margin.
  localparam int NEXT_PKT_ROOM = PKT_LEN + GB_LEN + 1 + CTRL_MARGIN;

  island_mode_t       state, state_d;
  logic [2:0]         phase, phase_d;
  logic [4:0]         pkt_bit_d;
  logic [IDX_W-1:0]   pkt_sel_d, win_idx;
  logic [NUM_REQ-1:0] grant_d, cur_win, cur_win_d, arb_mask, winner;
  logic [CNT_W-1:0]   pkt_cnt, pkt_cnt_d;
  logic               overrun_d, line_done, line_done_d, dip_d, arb_en;
  logic [10:0]        cx_w, ssx_w;
  logic               start_ok, room_ok, cnt_ok, ovr_hit;

  assign cx_w  = {1'b0, cx};
  assign ssx_w = {1'b0, screen_start_x};

  // Outputs are registered, so the transition is decided one column early:
  // the state register holds PREAMBLE while cx == ISL_START_X.
  assign start_ok = (state == CTRL) && !line_done
                 && ((cx_w + 11'd1) == 11'(ISL_START_X))
                 && (|req)
                 && (11'(ISL_START_X + ISL_MIN_LEN + CTRL_MARGIN) <= ssx_w);
  assign room_ok  = (cx_w + 11'(NEXT_PKT_ROOM)) <= ssx_w;
  assign cnt_ok   = pkt_cnt < CNT_W'(MAX_PKTS);
  assign ovr_hit  = (state != CTRL) && (cx == screen_start_x - 10'd1);

  hdmi_pkt_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
`ifdef HDMI_ISLAND_RR_EN
    .clk_pixel (clk_pixel),
    .reset     (reset),
`endif
    .req       (req),
    .mask      (arb_mask),
    .enable    (arb_en),
    .winner    (winner)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d     = state;
    phase_d     = phase + 3'd1;
    pkt_bit_d   = pkt_bit;
    pkt_sel_d   = pkt_sel;
    grant_d     = '0;
    cur_win_d   = cur_win;
    pkt_cnt_d   = pkt_cnt;
    overrun_d   = overrun;
    line_done_d = (cx == 10'd0) ? 1'b0 : line_done;
    arb_en      = 1'b0;
    arb_mask    = '0;

    if (ovr_hit) begin
      overrun_d = 1'b1;
      state_d   = CTRL;
      phase_d   = '0;
      pkt_bit_d = '0;
      pkt_sel_d = '0;
    end else begin
      case (state)
        CTRL: begin
          phase_d = '0;
          if (start_ok) begin
            state_d     = PREAMBLE;
            pkt_cnt_d   = '0;
            line_done_d = 1'b1;
          end
        end
        PREAMBLE: begin
          if (phase == 3'(PREAMBLE_LEN - 1)) begin
            state_d = GB_LEAD;
            phase_d = '0;
          end
        end
        GB_LEAD: begin
          if (phase == 3'(GB_LEN - 1)) begin
            // A packet is always sent; with no requester left it is the
            // null packet (grant stays 0, pkt_sel 0).
            arb_en    = 1'b1;
            state_d   = DATA;
            phase_d   = '0;
            pkt_bit_d = '0;
            pkt_cnt_d = pkt_cnt + 1'b1;
            grant_d   = winner;
            pkt_sel_d = win_idx;
            cur_win_d = winner;
          end
        end
        DATA: begin
          phase_d   = '0;
          pkt_bit_d = pkt_bit + 5'd1;
          if (pkt_bit == 5'(PKT_LEN - 1)) begin
            // Current winner may still hold req this cycle; mask it out.
            arb_mask = cur_win;
            arb_en   = cnt_ok && room_ok;
            if (|winner) begin
              pkt_bit_d = '0;
              pkt_cnt_d = pkt_cnt + 1'b1;
              grant_d   = winner;
              pkt_sel_d = win_idx;
              cur_win_d = winner;
            end else begin
              state_d   = GB_TRAIL;
              pkt_bit_d = '0;
              pkt_sel_d = '0;
            end
          end
        end
        GB_TRAIL: begin
          if (phase == 3'(GB_LEN - 1)) begin
            state_d = CTRL;
            phase_d = '0;
          end
        end
        default: begin
          state_d = CTRL;
          phase_d = '0;
        end
      endcase
    end

    dip_d = (state_d == GB_LEAD) || (state_d == DATA) || (state_d == GB_TRAIL);
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state              <= CTRL;
      phase              <= '0;
      pkt_bit            <= '0;
      pkt_sel            <= '0;
      grant              <= '0;
      cur_win            <= '0;
      pkt_cnt            <= '0;
      overrun            <= 1'b0;
      line_done          <= 1'b0;
      data_island_period <= 1'b0;
    end else begin
      state              <= state_d;
      phase              <= phase_d;
      pkt_bit            <= pkt_bit_d;
      pkt_sel            <= pkt_sel_d;
      grant              <= grant_d;
      cur_win            <= cur_win_d;
      pkt_cnt            <= pkt_cnt_d;
      overrun            <= overrun_d;
      line_done          <= line_done_d;
      data_island_period <= dip_d;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// tb/tb_hdmi_island_scheduler.sv - directed self-checking bench for hdmi_island_scheduler
module tb_hdmi_island_scheduler;
  import hdmi_pkg::*;

  localparam int LINE = 200;

  logic       clk_pixel;
  logic       reset;
  logic [9:0] cx;
  logic [9:0] screen_start_x;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] pkt_sel;
  logic [4:0] pkt_bit;
  logic [2:0] mode;
  logic       data_island_period;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int exp_l2 [3];
  int exp_l3 [3];
  logic ok;

  hdmi_island_scheduler dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .cx                 (cx),
    .screen_start_x     (screen_start_x),
    .req                (req),
    .grant              (grant),
    .pkt_sel            (pkt_sel),
    .pkt_bit            (pkt_bit),
    .mode               (mode),
    .data_island_period (data_island_period),
    .overrun            (overrun)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pixel);
    #1;
    cx = (cx == 10'(LINE - 1)) ? 10'd0 : cx + 10'd1;
  endtask

  task automatic run_to(input logic [9:0] t);
    for (int n = 0; n < 2 * LINE; n++) begin
      if (cx == t) break;
      step();
    end
    chk("run_to", 32'(cx), 32'(t));
  endtask

  task automatic check_grant(input string tag, input int e);
    logic [3:0] g;
    g = 4'b0001 << e;
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_sel"}, 32'(pkt_sel), 32'(e));
    req[e] = 1'b0;
  endtask

  task automatic full_line(input string tag, input int e0, input int e1, input int e2);
    run_to(10'd0);
    req = 4'hf;
    run_to(10'd20);
    check_grant({tag, "_p0"}, e0);
    run_to(10'd52);
    check_grant({tag, "_p1"}, e1);
    run_to(10'd84);
    check_grant({tag, "_p2"}, e2);
    run_to(10'd115);
    chk({tag, "_bit31"}, 32'(pkt_bit), 32'd31);
    run_to(10'd116);
    chk({tag, "_trail"}, 32'(mode), 32'(GB_TRAIL));
    chk({tag, "_trail_grant"}, 32'(grant), 32'd0);
    run_to(10'd118);
    chk({tag, "_ctrl"}, 32'(mode), 32'(CTRL));
  endtask

  initial begin
`ifdef HDMI_ISLAND_RR_EN
    exp_l2 = '{2, 3, 0};
    exp_l3 = '{1, 2, 3};
`else
    exp_l2 = '{0, 1, 2};
    exp_l3 = '{0, 1, 2};
`endif
    reset = 1'b1;
    cx = 10'd0;
    req = 4'h0;
    screen_start_x = 10'd160;
    repeat (2) @(posedge clk_pixel);
    #1;
    chk("rst_mode", 32'(mode), 32'(CTRL));
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_sel", 32'(pkt_sel), 32'd0);
    chk("rst_bit", 32'(pkt_bit), 32'd0);
    chk("rst_dip", 32'(data_island_period), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;

    // Single requester 1.
    req = 4'b0010;
    run_to(10'd9);
    chk("t1_cx9", 32'(mode), 32'(CTRL));
    step();
    chk("t1_pre10", 32'(mode), 32'(PREAMBLE));
    chk("t1_pre_dip", 32'(data_island_period), 32'd0);
    run_to(10'd17);
    chk("t1_pre17", 32'(mode), 32'(PREAMBLE));
    step();
    chk("t1_gb18", 32'(mode), 32'(GB_LEAD));
    chk("t1_gb_dip", 32'(data_island_period), 32'd1);
    run_to(10'd19);
    chk("t1_gb19", 32'(mode), 32'(GB_LEAD));
    step();
    chk("t1_data20", 32'(mode), 32'(DATA));
    chk("t1_bit0", 32'(pkt_bit), 32'd0);
    check_grant("t1", 1);
    step();
    chk("t1_pulse", 32'(grant), 32'd0);
    chk("t1_sel_held", 32'(pkt_sel), 32'd1);
    run_to(10'd51);
    chk("t1_bit31", 32'(pkt_bit), 32'd31);
    step();
    chk("t1_trail52", 32'(mode), 32'(GB_TRAIL));
    run_to(10'd53);
    chk("t1_trail53", 32'(mode), 32'(GB_TRAIL));
    step();
    chk("t1_ctrl54", 32'(mode), 32'(CTRL));
    chk("t1_ctrl_dip", 32'(data_island_period), 32'd0);

    // All requesters held for two lines.
    full_line("l2", exp_l2[0], exp_l2[1], exp_l2[2]);
    full_line("l3", exp_l3[0], exp_l3[1], exp_l3[2]);

    // No room for an island: screen_start_x = 60.
    run_to(10'd0);
    screen_start_x = 10'd60;
    req = 4'b0001;
    ok = 1'b1;
    for (int n = 0; n < LINE - 1; n++) begin
      step();
      if (mode !== 3'(CTRL) || grant !== 4'd0) ok = 1'b0;
    end
    chk("t3_ctrl_all_line", 32'(ok), 32'd1);

    // Null packet: req withdrawn during the preamble.
    run_to(10'd0);
    screen_start_x = 10'd160;
    req = 4'b0001;
    run_to(10'd12);
    chk("t4_pre", 32'(mode), 32'(PREAMBLE));
    req = 4'b0000;
    run_to(10'd20);
    chk("t4_data", 32'(mode), 32'(DATA));
    chk("t4_grant", 32'(grant), 32'd0);
    chk("t4_sel", 32'(pkt_sel), 32'd0);
    run_to(10'd52);
    chk("t4_trail", 32'(mode), 32'(GB_TRAIL));

    // Reset mid-packet.
    run_to(10'd0);
    req = 4'b0001;
    run_to(10'd20);
    chk("t5_grant", 32'(grant), 32'd1);
    run_to(10'd30);
    chk("t5_bit10", 32'(pkt_bit), 32'd10);
    reset = 1'b1;
    #1;
    chk("t5_rst_mode", 32'(mode), 32'(CTRL));
    chk("t5_rst_bit", 32'(pkt_bit), 32'd0);
    chk("t5_rst_dip", 32'(data_island_period), 32'd0);
    step();
    chk("t5_edge_mode", 32'(mode), 32'(CTRL));
    chk("t5_edge_grant", 32'(grant), 32'd0);
    chk("t5_edge_sel", 32'(pkt_sel), 32'd0);
    reset = 1'b0;
    ok = 1'b1;
    for (int n = 0; n < 2 * LINE; n++) begin
      if (cx == 10'd10) break;
      if (mode !== 3'(CTRL)) ok = 1'b0;
      step();
    end
    chk("t5_idle_until_start", 32'(ok), 32'd1);
    chk("t5_restart", 32'(mode), 32'(PREAMBLE));

    // Overrun: cx jumps to screen_start_x-1 during DATA.
    run_to(10'd25);
    chk("t6_data", 32'(mode), 32'(DATA));
    @(posedge clk_pixel);
    #1;
    cx = 10'd159;
    chk("t6_before", 32'(overrun), 32'd0);
    chk("t6_still_data", 32'(mode), 32'(DATA));
    step();
    chk("t6_ovr", 32'(overrun), 32'd1);
    chk("t6_ctrl", 32'(mode), 32'(CTRL));
    chk("t6_dip", 32'(data_island_period), 32'd0);
    run_to(10'd0);
    run_to(10'd50);
    chk("t6_sticky", 32'(overrun), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_cleared", 32'(overrun), 32'd0);
    step();
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
